// File: rtl/system_nios2_oci_pkg.sv
// Shared constants, frame tags and frame builders for the OCI trace path.
package system_nios2_oci_pkg;
    localparam int TW_W      = 36;
    localparam int DCT_BUF_W = 30;
    localparam int DCT_CNT_W = 4;
    localparam int CODE_W    = 2;
    localparam int ADDR_W    = 32;

    localparam logic [DCT_CNT_W-1:0] DCT_MAX  = 4'd15;
    localparam logic [1:0]           TAG_DCT  = 2'b01;
    localparam logic [3:0]           TAG_ADDR = 4'b1000;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [TW_W-1:0] dct_frame(input logic [DCT_CNT_W-1:0] cnt,
                                                  input logic [DCT_BUF_W-1:0] buffer);
        return {TAG_DCT, cnt, buffer};
    endfunction

    function automatic logic [TW_W-1:0] addr_frame(input logic [ADDR_W-1:0] payload);
        return {TAG_ADDR, payload};
    endfunction
endpackage

// File: rtl/system_nios2_oci_dct_sequencer_if.sv
// Code/address/trace-word handshakes between trace sources, sequencer and memory writer.
interface system_nios2_oci_dct_sequencer_if;
    import system_nios2_oci_pkg::*;

    logic                 code_valid;
    logic [CODE_W-1:0]    code;
    logic                 code_ready;
    logic                 addr_valid;
    logic [ADDR_W-1:0]    addr_payload;
    logic                 addr_ready;
    logic                 flush;
    logic                 tw_valid;
    logic [TW_W-1:0]      tw;
    logic                 tw_ready;
    logic [DCT_BUF_W-1:0] dct_buffer;
    logic [DCT_CNT_W-1:0] dct_count;

    modport slave (
        input  code_valid, code, addr_valid, addr_payload, flush, tw_ready,
        output code_ready, addr_ready, tw_valid, tw, dct_buffer, dct_count
    );

    modport master (
        output code_valid, code, addr_valid, addr_payload, flush, tw_ready,
        input  code_ready, addr_ready, tw_valid, tw, dct_buffer, dct_count
    );
endinterface

// File: rtl/system_nios2_oci_dct_packer.sv
// Code shift register, code counter and idle sync timer for the DCT buffer.
module system_nios2_oci_dct_packer
    import system_nios2_oci_pkg::*;
#(
    parameter int SYNC_INTERVAL = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 code_acc,
    input  logic [CODE_W-1:0]    code,
    input  logic                 load,
    output logic [DCT_BUF_W-1:0] dct_buffer,
    output logic [DCT_CNT_W-1:0] dct_count,
    output logic                 sync_exp
);
    localparam int TMR_W      = (SYNC_INTERVAL > 2) ? $clog2(SYNC_INTERVAL) : 1;
    localparam int TMR_LAST_I = (SYNC_INTERVAL > 0) ? SYNC_INTERVAL - 1 : 0;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_LAST_I[TMR_W-1:0];

    logic [TMR_W-1:0] timer;

    // Timer saturates at its terminal value so expiry stays asserted until the frame loads.
    assign sync_exp = (SYNC_INTERVAL != 0) && (dct_count != '0) && (timer == TMR_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_buffer <= '0;
            dct_count  <= '0;
            timer      <= '0;
        end else if (load) begin
            dct_buffer <= '0;
            dct_count  <= '0;
            timer      <= '0;
        end else if (code_acc) begin
            dct_buffer <= {dct_buffer[DCT_BUF_W-CODE_W-1:0], code};
            dct_count  <= dct_count + 1'b1;
            timer      <= '0;
        end else if (dct_count != '0 && timer != TMR_LAST) begin
            timer      <= timer + 1'b1;
        end
    end
endmodule

// File: rtl/system_nios2_oci_dct_sequencer.sv
// Arbitrates DCT frames and address packets onto the single trace-word output slot.
module system_nios2_oci_dct_sequencer
    import system_nios2_oci_pkg::*;
#(
    parameter int SYNC_INTERVAL = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic trc_on,
    system_nios2_oci_dct_sequencer_if.slave bus
);
    slot_state_e          state, state_nxt;
    logic [TW_W-1:0]      tw_q;
    logic                 flush_pend;
    logic [DCT_BUF_W-1:0] dct_buffer;
    logic [DCT_CNT_W-1:0] dct_count;
    logic                 sync_exp;
    logic                 slot_free, cnt_nz, cnt_full;
    logic                 dct_load, addr_load, code_ready, code_acc;

    system_nios2_oci_dct_packer #(.SYNC_INTERVAL(SYNC_INTERVAL)) u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .code_acc   (code_acc),
        .code       (bus.code),
        .load       (dct_load),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .sync_exp   (sync_exp)
    );

    always_comb begin
        slot_free  = (state == SLOT_EMPTY) || bus.tw_ready;
        cnt_nz     = (dct_count != '0);
        cnt_full   = (dct_count == DCT_MAX);
        // A pending address forces the partial frame out first so codes keep their order.
        dct_load   = reset_n && slot_free && cnt_nz &&
                     (cnt_full || bus.addr_valid || flush_pend || sync_exp || !trc_on);
        addr_load  = reset_n && slot_free && !cnt_nz && bus.addr_valid && trc_on;
        code_ready = reset_n && trc_on && !cnt_full && !bus.addr_valid && !dct_load;
        code_acc   = bus.code_valid && code_ready;

        state_nxt = state;
        if (dct_load || addr_load)
            state_nxt = SLOT_FULL;
        else if (state == SLOT_FULL && bus.tw_ready)
            state_nxt = SLOT_EMPTY;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= SLOT_EMPTY;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tw_q       <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (dct_load)
                tw_q <= dct_frame(dct_count, dct_buffer);
            else if (addr_load)
                tw_q <= addr_frame(bus.addr_payload);

            if (dct_load)
                flush_pend <= bus.flush && code_acc;
            else if (bus.flush)
                flush_pend <= 1'b1;
            else if (!cnt_nz)
                flush_pend <= 1'b0;
        end
    end

    assign bus.code_ready = code_ready;
    assign bus.addr_ready = addr_load;
    assign bus.tw_valid   = (state == SLOT_FULL);
    assign bus.tw         = tw_q;
    assign bus.dct_buffer = dct_buffer;
    assign bus.dct_count  = dct_count;
endmodule

// File: tb/tb_system_nios2_oci_dct_sequencer.sv
// Directed bench: cycle table for ordering/trc_on, hand sequences for fill, back-pressure, sync, flush, reset.
module tb_system_nios2_oci_dct_sequencer;
    import system_nios2_oci_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic trc_on  = 1'b0;

    system_nios2_oci_dct_sequencer_if bus();

    system_nios2_oci_dct_sequencer #(.SYNC_INTERVAL(64)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .trc_on  (trc_on),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        trc;
        logic        cv;
        logic [1:0]  c;
        logic        av;
        logic [31:0] ap;
        logic        tr;
        logic        x_cr;
        logic        x_ar;
        logic        x_tv;
        logic [35:0] x_tw;
        logic [3:0]  x_cnt;
    } vec_t;

    vec_t vt[10];

    // Offer one code value until n are accepted or the cycle bound runs out; ends idle at a negedge.
    task automatic offer_codes(input int n, input logic [1:0] c, input int bound, output int acc);
        int cyc;
        acc = 0;
        cyc = 0;
        while (acc < n && cyc < bound) begin
            @(negedge clk);
            bus.code_valid = 1'b1;
            bus.code       = c;
            #1;
            if (bus.code_ready) acc++;
            cyc++;
        end
        @(negedge clk);
        bus.code_valid = 1'b0;
    endtask

    task automatic wait_frame(input int bound, output logic got, output logic [35:0] w, output int cycles);
        got = 1'b0;
        w = '0;
        cycles = bound;
        for (int k = 0; k < bound; k++) begin
            #1;
            if (bus.tw_valid) begin
                got = 1'b1;
                w = bus.tw;
                cycles = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [35:0] f_a, f_addr, f_t, w;
        logic got, stable;
        int acc, cyc, frames;

        f_a    = {2'b01, 4'd3, 30'h1B};
        f_addr = {4'b1000, 32'h0000_1234};
        f_t    = {2'b01, 4'd1, 30'h2};
        //          trc cv  c     av  ap            tr   cr  ar  tv  tw      cnt
        vt[0] = '{1'b1, 1'b1, 2'b01, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 36'h0,  4'd0};
        vt[1] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 36'h0,  4'd1};
        vt[2] = '{1'b1, 1'b1, 2'b11, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 36'h0,  4'd2};
        vt[3] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 36'h0,  4'd3};
        vt[4] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h1234, 1'b1, 1'b0, 1'b1, 1'b1, f_a,    4'd0};
        vt[5] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b1, f_addr, 4'd0};
        vt[6] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 36'h0,  4'd0};
        vt[7] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 36'h0,  4'd1};
        vt[8] = '{1'b0, 1'b0, 2'b00, 1'b1, 32'h5,    1'b1, 1'b0, 1'b0, 1'b1, f_t,    4'd0};
        vt[9] = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 36'h0,  4'd0};

        // Reset state, with upstream requests active to see the ready gating.
        trc_on = 1'b1;
        bus.code_valid = 1'b1;
        bus.code = 2'b00;
        bus.addr_valid = 1'b1;
        bus.addr_payload = 32'h0;
        bus.flush = 1'b0;
        bus.tw_ready = 1'b1;
        #22;
        chk("rst tw_valid", bus.tw_valid, 0);
        chk("rst tw", bus.tw, 0);
        chk("rst dct_count", bus.dct_count, 0);
        chk("rst dct_buffer", bus.dct_buffer, 0);
        chk("rst code_ready", bus.code_ready, 0);
        chk("rst addr_ready", bus.addr_ready, 0);
        @(negedge clk);
        bus.code_valid = 1'b0;
        bus.addr_valid = 1'b0;
        reset_n = 1'b1;

        // Ordering of codes vs address, and trc_on falling.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            trc_on = vt[i].trc;
            bus.code_valid = vt[i].cv;
            bus.code = vt[i].c;
            bus.addr_valid = vt[i].av;
            bus.addr_payload = vt[i].ap;
            bus.tw_ready = vt[i].tr;
            #1;
            chk($sformatf("v%0d code_ready", i), bus.code_ready, vt[i].x_cr);
            chk($sformatf("v%0d addr_ready", i), bus.addr_ready, vt[i].x_ar);
            chk($sformatf("v%0d tw_valid", i), bus.tw_valid, vt[i].x_tv);
            chk($sformatf("v%0d dct_count", i), bus.dct_count, vt[i].x_cnt);
            if (vt[i].x_tv) chk($sformatf("v%0d tw", i), bus.tw, vt[i].x_tw);
        end
        @(negedge clk);
        trc_on = 1'b1;
        bus.addr_valid = 1'b0;
        bus.code_valid = 1'b0;

        // Full frame of 15 codes with no back-pressure.
        acc = 0;
        cyc = 0;
        while (acc < 15 && cyc < 40) begin
            @(negedge clk);
            bus.code_valid = 1'b1;
            bus.code = 2'b10;
            #1;
            if (bus.code_ready) acc++;
            cyc++;
        end
        chk("full accepts", acc, 15);
        chk("full fill cycles", cyc, 15);
        @(negedge clk);
        #1;
        chk("full count", bus.dct_count, 15);
        chk("full buffer", bus.dct_buffer, 30'h2AAAAAAA);
        chk("full code_ready low", bus.code_ready, 0);
        @(negedge clk);
        bus.code_valid = 1'b0;
        #1;
        chk("full tw_valid", bus.tw_valid, 1);
        chk("full tw", bus.tw, {2'b01, 4'hF, 30'h2AAAAAAA});
        chk("full count cleared", bus.dct_count, 0);
        chk("full code_ready back", bus.code_ready, 1);

        // Back-pressure: slot held by an address frame while 20 codes are offered.
        @(negedge clk);
        bus.tw_ready = 1'b0;
        bus.addr_valid = 1'b1;
        bus.addr_payload = 32'hCAFE_0001;
        #1;
        chk("bp addr_ready", bus.addr_ready, 1);
        @(negedge clk);
        bus.addr_valid = 1'b0;
        bus.code_valid = 1'b1;
        bus.code = 2'b11;
        acc = 0;
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (bus.code_ready) acc++;
            if (!bus.tw_valid || bus.tw !== {4'b1000, 32'hCAFE_0001}) stable = 1'b0;
        end
        chk("bp accepts", acc, 15);
        chk("bp tw stable", stable, 1);
        @(negedge clk);
        #1;
        chk("bp count held", bus.dct_count, 15);
        chk("bp code_ready", bus.code_ready, 0);
        @(negedge clk);
        bus.code_valid = 1'b0;
        bus.tw_ready = 1'b1;
        #1;
        chk("bp release code_ready", bus.code_ready, 0);
        @(negedge clk);
        #1;
        chk("bp frame", bus.tw, {2'b01, 4'hF, 30'h3FFFFFFF});
        offer_codes(5, 2'b01, 20, acc);
        chk("bp rest accepts", acc, 5);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        wait_frame(10, got, w, cyc);
        chk("bp rest got", got, 1);
        chk("bp rest frame", w, {2'b01, 4'd5, 30'h155});

        // Sync flush after 64 idle cycles.
        offer_codes(2, 2'b10, 10, acc);
        wait_frame(80, got, w, cyc);
        chk("sync got", got, 1);
        chk("sync delay", cyc, 64);
        chk("sync frame", w, {2'b01, 4'd2, 30'hA});
        frames = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (bus.tw_valid) frames++;
        end
        chk("sync empty no frame", frames, 0);

        // flush with an empty buffer, then with four codes.
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        frames = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (bus.tw_valid) frames++;
            @(negedge clk);
        end
        chk("flush empty frames", frames, 0);
        offer_codes(1, 2'b00, 10, acc);
        offer_codes(1, 2'b01, 10, acc);
        offer_codes(1, 2'b10, 10, acc);
        offer_codes(1, 2'b11, 10, acc);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        frames = 0;
        w = '0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.tw_valid) begin
                frames++;
                w = bus.tw;
            end
            @(negedge clk);
        end
        chk("flush4 frames", frames, 1);
        chk("flush4 frame", w, {2'b01, 4'd4, 30'h1B});

        // Reset while a frame is pending and seven codes are buffered.
        bus.tw_ready = 1'b0;
        bus.addr_valid = 1'b1;
        bus.addr_payload = 32'h77;
        @(negedge clk);
        bus.addr_valid = 1'b0;
        offer_codes(7, 2'b11, 20, acc);
        #1;
        chk("mid tw_valid", bus.tw_valid, 1);
        chk("mid count", bus.dct_count, 7);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst tw_valid", bus.tw_valid, 0);
        chk("arst count", bus.dct_count, 0);
        chk("arst buffer", bus.dct_buffer, 0);
        chk("arst code_ready", bus.code_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.tw_ready = 1'b1;
        offer_codes(2, 2'b10, 10, acc);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        wait_frame(10, got, w, cyc);
        chk("post rst got", got, 1);
        chk("post rst frame", w, {2'b01, 4'd2, 30'hA});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
